// File: rtl/alu_wb_stage.sv
// rtl/alu_wb_stage.sv - ALU writeback stage: flag capture, 2-entry result FIFO, overflow status
//
// Purpose:
//   Sits directly behind the 4-bit combinational ALU. Each accepted result is
//   stored with its opcode and derived {V,N,Z} flags in a 2-entry FIFO, so the
//   ALU can keep issuing while the consumer stalls. A sticky overflow bit and a
//   saturating overflow counter are kept for debug/status.
//
// Ports:
//   clk, rst            clock (rising edge) and asynchronous active-high reset
//   in_valid/in_ready   upstream handshake; push when both are high
//   in_op, in_res       opcode and two's-complement result from the ALU
//   in_err              ALU signed-overflow indication
//   out_valid/out_ready downstream handshake; pop when both are high
//   out_res, out_op     head entry result and opcode (held when empty)
//   out_flags           head entry flags {V,N,Z} (held when empty)
//   clr_stat            synchronous clear of ovf_sticky and ovf_count
//   ovf_sticky          set by any accepted overflow since the last clear
//   ovf_count           accepted overflows, saturating at all-ones

module alu_wb_stage #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_res,
    input  logic             in_err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic [1:0]       out_op,
    output logic [2:0]       out_flags,
    input  logic             clr_stat,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // FIFO storage and pointers
    logic [1:0][WIDTH-1:0] mem_res_q, mem_res_d;
    logic [1:0][1:0]       mem_op_q,  mem_op_d;
    logic [1:0][2:0]       mem_flg_q, mem_flg_d;
    logic                  wr_ptr_q,  wr_ptr_d;
    logic                  rd_ptr_q,  rd_ptr_d;
    logic [1:0]            occ_q,     occ_d;

    // Registered head outputs; they hold their last value while empty
    logic [WIDTH-1:0]      out_res_q,   out_res_d;
    logic [1:0]            out_op_q,    out_op_d;
    logic [2:0]            out_flags_q, out_flags_d;

    // Status
    logic                  sticky_q, sticky_d;
    logic [CNT_W-1:0]      cnt_q,    cnt_d;

    logic                  push;
    logic                  pop;
    logic [2:0]            flags_in;

    // Handshake signals come only from registered occupancy, so there is no
    // combinational path from out_ready to in_ready.
    assign in_ready  = (occ_q != 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // An err on the logic ops (AND-NOT, XOR) is meaningless and is dropped.
    assign flags_in = {in_err & ~in_op[1], in_res[WIDTH-1], (in_res == '0)};

    always_comb begin
        mem_res_d   = mem_res_q;
        mem_op_d    = mem_op_q;
        mem_flg_d   = mem_flg_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        out_res_d   = out_res_q;
        out_op_d    = out_op_q;
        out_flags_d = out_flags_q;
        sticky_d    = sticky_q;
        cnt_d       = cnt_q;

        if (push) begin
            mem_res_d[wr_ptr_q] = in_res;
            mem_op_d[wr_ptr_q]  = in_op;
            mem_flg_d[wr_ptr_q] = flags_in;
            wr_ptr_d            = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase

        // Head registers track the entry the read pointer will address next
        // cycle. Reading from the next-state memory lets a push into an empty
        // FIFO, or a push+pop at occupancy 1, land on the outputs one cycle later.
        if (occ_d != 2'd0) begin
            out_res_d   = mem_res_d[rd_ptr_d];
            out_op_d    = mem_op_d[rd_ptr_d];
            out_flags_d = mem_flg_d[rd_ptr_d];
        end

        // Clear has priority; a coincident overflow event is dropped.
        if (clr_stat) begin
            sticky_d = 1'b0;
            cnt_d    = '0;
        end else if (push && flags_in[2]) begin
            sticky_d = 1'b1;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_res_q   <= '0;
            mem_op_q    <= '0;
            mem_flg_q   <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            occ_q       <= 2'd0;
            out_res_q   <= '0;
            out_op_q    <= 2'd0;
            out_flags_q <= 3'd0;
            sticky_q    <= 1'b0;
            cnt_q       <= '0;
        end else begin
            mem_res_q   <= mem_res_d;
            mem_op_q    <= mem_op_d;
            mem_flg_q   <= mem_flg_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            out_res_q   <= out_res_d;
            out_op_q    <= out_op_d;
            out_flags_q <= out_flags_d;
            sticky_q    <= sticky_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_res    = out_res_q;
    assign out_op     = out_op_q;
    assign out_flags  = out_flags_q;
    assign ovf_sticky = sticky_q;
    assign ovf_count  = cnt_q;

endmodule

// File: tb/tb_alu_wb_stage.sv
// tb/tb_alu_wb_stage.sv - directed self-checking bench for alu_wb_stage

module tb_alu_wb_stage;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] in_op;
    logic [3:0] in_res;
    logic       in_err;
    logic       out_ready;
    logic       clr_stat;

    logic       in_ready,  in_ready_2;
    logic       out_valid, out_valid_2;
    logic [3:0] out_res,   out_res_2;
    logic [1:0] out_op,    out_op_2;
    logic [2:0] out_flags, out_flags_2;
    logic       ovf_sticky, ovf_sticky_2;
    logic [7:0] ovf_count;
    logic [1:0] ovf_count_2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_wb_stage #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_res(in_res), .in_err(in_err),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_res(out_res), .out_op(out_op), .out_flags(out_flags),
        .clr_stat(clr_stat), .ovf_sticky(ovf_sticky), .ovf_count(ovf_count)
    );

    alu_wb_stage #(.WIDTH(4), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready_2),
        .in_op(in_op), .in_res(in_res), .in_err(in_err),
        .out_valid(out_valid_2), .out_ready(out_ready),
        .out_res(out_res_2), .out_op(out_op_2), .out_flags(out_flags_2),
        .clr_stat(clr_stat), .ovf_sticky(ovf_sticky_2), .ovf_count(ovf_count_2)
    );

    task automatic step();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] res, input logic err);
        in_valid = v;
        in_op    = op;
        in_res   = res;
        in_err   = err;
    endtask

    task automatic test_reset();
        rst = 1'b1; drive(1'b0, 2'd0, 4'd0, 1'b0); out_ready = 1'b1; clr_stat = 1'b0;
        step(); step();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if ({out_res, out_op, out_flags} !== 9'd0) begin errors++; $display("FAIL reset_outputs: got res=%h op=%h flags=%b expected 0", out_res, out_op, out_flags); end
        checks++; if ({ovf_sticky, ovf_count} !== 9'd0) begin errors++; $display("FAIL reset_status: got sticky=%b count=%0d expected 0", ovf_sticky, ovf_count); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        drive(1'b1, 2'b00, 4'b0111, 1'b0);
        step();
        drive(1'b0, 2'b00, 4'd0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b expected 1", out_valid); end
        checks++; if (out_res !== 4'd7) begin errors++; $display("FAIL basic_res: got %h expected 7", out_res); end
        checks++; if (out_flags !== 3'b000) begin errors++; $display("FAIL basic_flags: got %b expected 000", out_flags); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b expected 0", out_valid); end
        checks++; if (out_res !== 4'd7) begin errors++; $display("FAIL basic_hold: got %h expected 7", out_res); end
    endtask

    task automatic test_flags();
        out_ready = 1'b1;
        drive(1'b1, 2'b00, 4'b1000, 1'b1);       // 5+3 overflow
        step();
        checks++; if (out_flags !== 3'b110) begin errors++; $display("FAIL flags_add_ovf: got %b expected 110", out_flags); end
        checks++; if (ovf_sticky !== 1'b1) begin errors++; $display("FAIL flags_sticky: got %b expected 1", ovf_sticky); end
        checks++; if (ovf_count !== 8'd1) begin errors++; $display("FAIL flags_count1: got %0d expected 1", ovf_count); end
        drive(1'b1, 2'b11, 4'b0000, 1'b1);       // xor with err: ignored
        step();
        checks++; if (out_flags !== 3'b001) begin errors++; $display("FAIL flags_xor_zero: got %b expected 001", out_flags); end
        checks++; if (out_op !== 2'b11) begin errors++; $display("FAIL flags_xor_op: got %b expected 11", out_op); end
        checks++; if (ovf_count !== 8'd1) begin errors++; $display("FAIL flags_count_xor: got %0d expected 1", ovf_count); end
        drive(1'b1, 2'b10, 4'b1100, 1'b1);       // and-not with err: ignored
        step();
        checks++; if (out_flags !== 3'b010) begin errors++; $display("FAIL flags_andn: got %b expected 010", out_flags); end
        drive(1'b1, 2'b01, 4'b1010, 1'b0);       // sub, negative
        step();
        checks++; if ({out_op, out_res, out_flags} !== {2'b01, 4'b1010, 3'b010}) begin errors++; $display("FAIL flags_sub_neg: got op=%b res=%h flags=%b expected op=01 res=a flags=010", out_op, out_res, out_flags); end
        checks++; if (ovf_count !== 8'd1) begin errors++; $display("FAIL flags_count_end: got %0d expected 1", ovf_count); end
        drive(1'b0, 2'b00, 4'd0, 1'b0);
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flags_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 4'd1, 1'b0);
        step();
        checks++; if ({in_ready, out_valid, out_res} !== {1'b1, 1'b1, 4'd1}) begin errors++; $display("FAIL bp_first: got ready=%b valid=%b res=%h expected 1 1 1", in_ready, out_valid, out_res); end
        in_res = 4'd2;
        step();
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got %b expected 0", in_ready); end
        in_res = 4'd3;
        step();
        checks++; if ({in_ready, out_res} !== {1'b0, 4'd1}) begin errors++; $display("FAIL bp_hold: got ready=%b res=%h expected 0 1", in_ready, out_res); end
        out_ready = 1'b1;                          // pop at full; push must not be taken
        step();
        checks++; if ({in_ready, out_valid, out_res} !== {1'b1, 1'b1, 4'd2}) begin errors++; $display("FAIL bp_second: got ready=%b valid=%b res=%h expected 1 1 2", in_ready, out_valid, out_res); end
        step();
        in_valid = 1'b0;
        checks++; if ({out_valid, out_res} !== {1'b1, 4'd3}) begin errors++; $display("FAIL bp_third: got valid=%b res=%h expected 1 3", out_valid, out_res); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 4'd4, 1'b0);
        step();
        in_res = 4'd5; out_ready = 1'b1;           // push+pop at occupancy 1
        step();
        drive(1'b0, 2'b00, 4'd0, 1'b0);
        checks++; if ({out_valid, out_res, in_ready} !== {1'b1, 4'd5, 1'b1}) begin errors++; $display("FAIL b2b_head: got valid=%b res=%h ready=%b expected 1 5 1", out_valid, out_res, in_ready); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_occ1: got %b expected 0", out_valid); end
    endtask

    task automatic test_saturation();
        out_ready = 1'b1; clr_stat = 1'b1;
        step();
        clr_stat = 1'b0;
        checks++; if ({ovf_sticky, ovf_count, ovf_count_2} !== 11'd0) begin errors++; $display("FAIL sat_clear: got sticky=%b c8=%0d c2=%0d expected 0", ovf_sticky, ovf_count, ovf_count_2); end
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'b00, 4'b1000, 1'b1);
            step();
        end
        checks++; if (ovf_count_2 !== 2'd3) begin errors++; $display("FAIL sat_count2: got %0d expected 3", ovf_count_2); end
        checks++; if (ovf_count !== 8'd5) begin errors++; $display("FAIL sat_count8: got %0d expected 5", ovf_count); end
        checks++; if (ovf_sticky_2 !== 1'b1) begin errors++; $display("FAIL sat_sticky: got %b expected 1", ovf_sticky_2); end
        clr_stat = 1'b1;
        drive(1'b1, 2'b01, 4'b0111, 1'b1);        // clear wins over overflow push
        step();
        clr_stat = 1'b0;
        drive(1'b0, 2'b00, 4'd0, 1'b0);
        checks++; if ({ovf_sticky, ovf_count, ovf_sticky_2, ovf_count_2} !== 12'd0) begin errors++; $display("FAIL sat_clr_wins: got s=%b c8=%0d s2=%b c2=%0d expected 0", ovf_sticky, ovf_count, ovf_sticky_2, ovf_count_2); end
        checks++; if ({out_valid, out_res, out_op, out_flags} !== {1'b1, 4'd7, 2'b01, 3'b100}) begin errors++; $display("FAIL sat_entry: got v=%b res=%h op=%b flags=%b expected 1 7 01 100", out_valid, out_res, out_op, out_flags); end
        step();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(1'b1, 2'b00, 4'b1000, 1'b1);
        step();
        in_res = 4'd9;
        step();
        drive(1'b0, 2'b00, 4'd0, 1'b0);
        checks++; if ({out_valid, in_ready, ovf_count} !== {1'b1, 1'b0, 8'd2}) begin errors++; $display("FAIL arst_pre: got valid=%b ready=%b count=%0d expected 1 0 2", out_valid, in_ready, ovf_count); end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if ({out_valid, in_ready, ovf_count, ovf_sticky} !== {1'b0, 1'b1, 8'd0, 1'b0}) begin errors++; $display("FAIL arst_now: got valid=%b ready=%b count=%0d sticky=%b expected 0 1 0 0", out_valid, in_ready, ovf_count, ovf_sticky); end
        checks++; if ({out_res, out_op, out_flags} !== 9'd0) begin errors++; $display("FAIL arst_outputs: got res=%h op=%b flags=%b expected 0", out_res, out_op, out_flags); end
        step();
        rst = 1'b0;
        step();
        checks++; if ({out_valid, in_ready} !== 2'b01) begin errors++; $display("FAIL arst_after: got valid=%b ready=%b expected 0 1", out_valid, in_ready); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flags();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
